cacheline_adapter: RTL and testbench
====================================

// Module: cacheline_adapter
// PURPOSE
//  Converts 256-bit cache-line requests (prefetcher/cache dfp side) into 64-bit burst memory
//  transactions (BURST_LEN beats). Sits directly downstream of the prefetcher and upstream of
//  burst memory. One outstanding line at a time; reads and writes share one FSM.
// PARAMETERS
//  BEAT_W     64  memory data beat width (bits)
//  BURST_LEN  4   beats per line; LINE_W = BEAT_W*BURST_LEN = 256
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, synchronous, active-high
//  ufp_addr     in   32      line address; bits [4:0] forced to 0 when latched
//  ufp_read     in   1       line read request, held high until ufp_resp
//  ufp_write    in   1       line write request, held high until ufp_resp
//  ufp_wdata    in   256     write line data
//  ufp_rdata    out  256     read line data, valid while ufp_resp=1
//  ufp_resp     out  1       one-cycle completion pulse
//  bmem_addr    out  32      burst base address
//  bmem_read    out  1       read burst request (single cycle, accepted when bmem_ready)
//  bmem_write   out  1       write beat valid (BURST_LEN accepted cycles per burst)
//  bmem_wdata   out  64      write beat
//  bmem_ready   in   1       memory accepts request/beat this cycle
//  bmem_raddr   in   32      base address of returning read burst
//  bmem_rdata   in   64      read beat
//  bmem_rvalid  in   1       read beat valid
//  addr_err     out  1       only with CACHELINE_ADAPTER_ADDR_CHECK_EN; sticky mismatch flag
// BEHAVIOUR
//  - All outputs registered. Reset: FSM=IDLE, beat_cnt=0, ufp_resp=0, ufp_rdata=0,
//    bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, addr_err=0.
//  - States: IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE.
//  - IDLE: ufp_read -> latch {ufp_addr[31:5],5'b0}, go RD_REQ; else ufp_write -> latch addr and
//    ufp_wdata, go WR_BURST. Both high: read wins (illegal stimulus, no error raised).
//  - RD_REQ: bmem_read=1, bmem_addr=latched; on bmem_ready go RD_WAIT, bmem_read drops next cycle.
//  - RD_WAIT: each bmem_rvalid stores bmem_rdata into line[BEAT_W*beat_cnt +: BEAT_W], beat_cnt++;
//    on beat BURST_LEN-1 go DONE. Beats need not be consecutive; gaps tolerated.
//  - WR_BURST: bmem_write=1, bmem_wdata=line[BEAT_W*beat_cnt +: BEAT_W]; beat advances only
//    when bmem_ready=1 (beat held otherwise); after last accepted beat go DONE.
//  - DONE: ufp_resp=1 for exactly one cycle (ufp_rdata=assembled line for reads, unchanged for
//    writes); beat_cnt=0; -> IDLE. New request sampled no earlier than the IDLE cycle after DONE.
//  - Min read latency: request cycle -> ufp_resp = 3 + memory latency + BURST_LEN-1 cycles.
//  - bmem_rvalid outside RD_WAIT ignored (no capture, no count change).
//  - beat_cnt is $clog2(BURST_LEN) bits; wraps to 0 at completion only, never mid-burst.
//  - Reset mid-burst: immediate return to IDLE with reset values; late beats from the aborted
//    burst arrive in IDLE and are dropped.
//  - ufp_addr/ufp_wdata changes after latch have no effect on the active burst.
// CONFIGURATION
//  - `CACHELINE_ADAPTER_ADDR_CHECK_EN defined: first beat in RD_WAIT compares bmem_raddr with the
//    latched address; mismatch sets addr_err (sticky until rst). Data capture is unaffected.
//  - Undefined: addr_err port and compare logic absent; bmem_raddr unused.
// STRUCTURE
//  - rv32i_types package: adapter_state_t enum (IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE),
//    localparams LINE_W=256, BEAT_W=64, BURST_LEN=4, LINE_OFFSET_BITS=5.
//  - Single module; no sub-module (FSM + counter + line register are tightly coupled).
// TESTING
//  1 Read 0x0000_1040, mem returns beats A,B,C,D back-to-back -> one bmem_read pulse, addr
//    0x1040; ufp_resp 1 cycle, ufp_rdata={D,C,B,A}.
//  2 Read 0x0000_105C -> bmem_addr=0x1040 (offset cleared); rvalid gaps of 2 cycles between
//    beats -> same data, ufp_resp only after 4th beat.
//  3 Write 0x2000, wdata={W3,W2,W1,W0}, bmem_ready low 3 cycles at beat 1 -> beats W0,W1,W2,W3
//    in order, W1 held while stalled; one ufp_resp after W3 accepted.
//  4 ufp_read=ufp_write=1 -> read burst issued, no bmem_write asserted.
//  5 rst after 2 read beats, then 2 stray rvalids, then new read 0x3000 -> strays dropped,
//    new line assembled correctly from fresh 4 beats.
//  6 ADDR_CHECK_EN: read 0x4000, bmem_raddr=0x4020 -> addr_err=1 and stays 1; data still
//    delivered. Without macro: no addr_err port, same data result.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types and sizing for the cache-line to burst-memory adapter
package rv32i_types;

    localparam int BEAT_W           = 64;
    localparam int BURST_LEN        = 4;
    localparam int LINE_W           = BEAT_W * BURST_LEN;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int BEAT_CNT_W       = $clog2(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_BURST,
        DONE
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - 256-bit cache-line requests to 64-bit burst memory transactions
//
// Optional feature macro: CACHELINE_ADAPTER_ADDR_CHECK_EN (adds addr_err and raddr compare).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ufp_addr/read/write/wdata     line request from the prefetcher/cache side
//   ufp_rdata, ufp_resp           assembled read line and one-cycle completion pulse
//   bmem_addr/read/write/wdata    burst request and write beats toward memory
//   bmem_ready                    memory accepts request/beat this cycle
//   bmem_raddr/rdata/rvalid       returning read beats
//   addr_err                      sticky read-address mismatch (macro builds only)
module cacheline_adapter
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ufp_addr,
    input  logic              ufp_read,
    input  logic              ufp_write,
    input  logic [LINE_W-1:0] ufp_wdata,
    output logic [LINE_W-1:0] ufp_rdata,
    output logic              ufp_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
    output logic              addr_err,
`endif
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BURST_LEN - 1);

    adapter_state_t          state_q, state_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [LINE_W-1:0]       ufp_rdata_d;
    logic                    ufp_resp_d;
    logic [31:0]             bmem_addr_d;
    logic                    bmem_read_d;
    logic                    bmem_write_d;
    logic [BEAT_W-1:0]       bmem_wdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every output is computed one cycle ahead here and registered below, so the
    // memory side sees bmem_read/bmem_write exactly while the FSM sits in the
    // matching state.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        line_d       = line_q;
        ufp_rdata_d  = ufp_rdata;
        ufp_resp_d   = 1'b0;
        bmem_addr_d  = bmem_addr;
        bmem_read_d  = bmem_read;
        bmem_write_d = bmem_write;
        bmem_wdata_d = bmem_wdata;

        unique case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                // Read takes priority when both requests are raised together.
                if (ufp_read) begin
                    bmem_addr_d = {ufp_addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
                    bmem_read_d = 1'b1;
                    state_d     = RD_REQ;
                end else if (ufp_write) begin
                    bmem_addr_d  = {ufp_addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
                    line_d       = ufp_wdata;
                    bmem_write_d = 1'b1;
                    bmem_wdata_d = ufp_wdata[BEAT_W-1:0];
                    state_d      = WR_BURST;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    bmem_read_d = 1'b0;
                    state_d     = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bmem_rvalid) begin
                    line_d[BEAT_W*beat_cnt_q +: BEAT_W] = bmem_rdata;
                    beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        ufp_rdata_d = line_d;
                        ufp_resp_d  = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        bmem_write_d = 1'b0;
                        ufp_resp_d   = 1'b1;
                        state_d      = DONE;
                    end else begin
                        bmem_wdata_d = line_q[BEAT_W*beat_cnt_d +: BEAT_W];
                    end
                end
            end
            DONE: begin
                beat_cnt_d = '0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            line_q     <= '0;
            ufp_rdata  <= '0;
            ufp_resp   <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            line_q     <= line_d;
            ufp_rdata  <= ufp_rdata_d;
            ufp_resp   <= ufp_resp_d;
            bmem_addr  <= bmem_addr_d;
            bmem_read  <= bmem_read_d;
            bmem_write <= bmem_write_d;
            bmem_wdata <= bmem_wdata_d;
        end
    end

`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
    // bmem_addr still holds the latched line address throughout RD_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (state_q == RD_WAIT && bmem_rvalid && beat_cnt_q == '0
                     && bmem_raddr != bmem_addr) begin
            addr_err <= 1'b1;
        end
    end

    logic unused_offset;
    assign unused_offset = ^ufp_addr[LINE_OFFSET_BITS-1:0];
`else
    logic unused_inputs;
    assign unused_inputs = ^{bmem_raddr, ufp_addr[LINE_OFFSET_BITS-1:0]};
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - directed table-driven bench for cacheline_adapter
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  ufp_addr;
    logic         ufp_read;
    logic         ufp_write;
    logic [255:0] ufp_wdata;
    logic [255:0] ufp_rdata;
    logic         ufp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
    logic         addr_err;
`endif

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .ufp_addr   (ufp_addr),
        .ufp_read   (ufp_read),
        .ufp_write  (ufp_write),
        .ufp_wdata  (ufp_wdata),
        .ufp_rdata  (ufp_rdata),
        .ufp_resp   (ufp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
        .addr_err   (addr_err),
`endif
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [255:0] last_rdata;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] line;
        int           gap;
        int           stall_beat;
        int           stall_cyc;
        logic [31:0]  exp_addr;
    } vec_t;

    vec_t vecs[5];

    task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int gap,
                           input logic [31:0] exp_addr, input logic [31:0] raddr, input bit both);
        int lat;
        int t;
        bit saw_write;
        @(negedge clk);
        ufp_addr   = addr;
        ufp_read   = 1'b1;
        ufp_write  = both;
        ufp_wdata  = {4{64'hBAD0_BAD0_BAD0_BAD0}};
        bmem_ready = 1'b1;
        lat = 0;
        t = 0;
        saw_write = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            t++;
            saw_write |= bmem_write;
        end while (!bmem_read && t < 20);
        if (!bmem_read) begin
            check("rd_req_timeout", 0, 1);
            ufp_read  = 1'b0;
            ufp_write = 1'b0;
            return;
        end
        check("rd_bmem_addr", bmem_addr, exp_addr);
        ufp_addr = 32'hDEAD_BEEF;
        @(negedge clk);
        lat++;
        check("rd_read_pulse_drop", bmem_read, 0);
        for (int i = 0; i < 4; i++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = line[64*i +: 64];
            bmem_raddr  = raddr;
            @(negedge clk);
            lat++;
            saw_write |= bmem_write;
            bmem_rvalid = 1'b0;
            bmem_rdata  = '0;
            if (i < 3) begin
                check("rd_no_early_resp", ufp_resp, 0);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    lat++;
                    saw_write |= bmem_write;
                end
            end
        end
        check("rd_resp", ufp_resp, 1);
        check("rd_rdata", ufp_rdata, line);
        check("rd_latency", lat, 6 + 3*gap);
        last_rdata = line;
        ufp_read  = 1'b0;
        ufp_write = 1'b0;
        @(negedge clk);
        check("rd_resp_one_cycle", ufp_resp, 0);
        check("rd_no_bmem_write", saw_write, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int stall_beat,
                            input int stall_cyc, input logic [31:0] exp_addr);
        int t;
        @(negedge clk);
        ufp_addr   = addr;
        ufp_write  = 1'b1;
        ufp_read   = 1'b0;
        ufp_wdata  = line;
        bmem_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bmem_write && t < 20);
        if (!bmem_write) begin
            check("wr_req_timeout", 0, 1);
            ufp_write = 1'b0;
            return;
        end
        check("wr_bmem_addr", bmem_addr, exp_addr);
        ufp_wdata = ~line;
        ufp_addr  = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            if (k == stall_beat) begin
                bmem_ready = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    check("wr_hold_valid", bmem_write, 1);
                    check("wr_hold_data", bmem_wdata, line[64*k +: 64]);
                    @(negedge clk);
                end
                bmem_ready = 1'b1;
            end
            check("wr_beat_valid", bmem_write, 1);
            check("wr_beat_data", bmem_wdata, line[64*k +: 64]);
            @(negedge clk);
            if (k < 3) begin
                check("wr_no_early_resp", ufp_resp, 0);
            end else begin
                check("wr_resp", ufp_resp, 1);
                check("wr_write_drop", bmem_write, 0);
                check("wr_rdata_unchanged", ufp_rdata, last_rdata);
            end
        end
        ufp_write = 1'b0;
        @(negedge clk);
        check("wr_resp_one_cycle", ufp_resp, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        vecs[0] = '{1'b0, 32'h0000_1040,
                    {64'hDDDD_DDDD_0000_0004, 64'hCCCC_CCCC_0000_0003,
                     64'hBBBB_BBBB_0000_0002, 64'hAAAA_AAAA_0000_0001},
                    0, 4, 0, 32'h0000_1040};
        vecs[1] = '{1'b0, 32'h0000_105C,
                    {64'hDDDD_DDDD_0000_0004, 64'hCCCC_CCCC_0000_0003,
                     64'hBBBB_BBBB_0000_0002, 64'hAAAA_AAAA_0000_0001},
                    2, 4, 0, 32'h0000_1040};
        vecs[2] = '{1'b1, 32'h0000_2000,
                    {64'h3333_0000_0000_0033, 64'h2222_0000_0000_0022,
                     64'h1111_0000_0000_0011, 64'h0000_0000_0000_0000},
                    0, 1, 3, 32'h0000_2000};
        vecs[3] = '{1'b1, 32'h0000_201F,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h5555_AAAA_5555_AAAA, 64'hFFFF_FFFF_FFFF_FFFF},
                    0, 4, 0, 32'h0000_2000};
        vecs[4] = '{1'b0, 32'hFFFF_FFE7,
                    {64'h8000_0000_0000_0008, 64'h4000_0000_0000_0004,
                     64'h2000_0000_0000_0002, 64'h1000_0000_0000_0001},
                    1, 4, 0, 32'hFFFF_FFE0};

        rst         = 1'b1;
        ufp_addr    = '0;
        ufp_read    = 1'b0;
        ufp_write   = 1'b0;
        ufp_wdata   = '0;
        bmem_ready  = 1'b1;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_resp", ufp_resp, 0);
        check("reset_rdata", ufp_rdata, 0);
        check("reset_bmem_read", bmem_read, 0);
        check("reset_bmem_write", bmem_write, 0);
        check("reset_bmem_addr", bmem_addr, 0);
        check("reset_bmem_wdata", bmem_wdata, 0);
`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
        check("reset_addr_err", addr_err, 0);
`endif
        rst = 1'b0;
        last_rdata = '0;

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].line, vecs[i].stall_beat, vecs[i].stall_cyc,
                         vecs[i].exp_addr);
            else
                do_read(vecs[i].addr, vecs[i].line, vecs[i].gap, vecs[i].exp_addr,
                        vecs[i].exp_addr, 1'b0);
        end

        // Read and write raised together: read burst only.
        do_read(32'h0000_6000, {64'h6666_0004, 64'h6666_0003, 64'h6666_0002, 64'h6666_0001},
                0, 32'h0000_6000, 32'h0000_6000, 1'b1);

        // Reset in the middle of a read burst, then stray beats while idle.
        @(negedge clk);
        ufp_addr = 32'h0000_5000;
        ufp_read = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bmem_read && t < 20);
        check("abort_req_seen", bmem_read, 1);
        @(negedge clk);
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'h0000_5000;
        bmem_rdata  = 64'h5A5A_0000_0000_0001;
        @(negedge clk);
        bmem_rdata  = 64'h5A5A_0000_0000_0002;
        @(negedge clk);
        bmem_rvalid = 1'b0;
        ufp_read    = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rdata_reset", ufp_rdata, 0);
        check("abort_bmem_addr_reset", bmem_addr, 0);
        check("abort_resp_reset", ufp_resp, 0);
        last_rdata = '0;
        for (int s = 0; s < 2; s++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = 64'hEEEE_EEEE_EEEE_EEEE;
            @(negedge clk);
            check("stray_no_resp", ufp_resp, 0);
            check("stray_no_read", bmem_read, 0);
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        do_read(32'h0000_3000, {64'h3000_0000_0000_00D4, 64'h3000_0000_0000_00C3,
                                64'h3000_0000_0000_00B2, 64'h3000_0000_0000_00A1},
                0, 32'h0000_3000, 32'h0000_3000, 1'b0);

`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
        check("addr_err_clear", addr_err, 0);
        do_read(32'h0000_4000, {64'h4444_0004, 64'h4444_0003, 64'h4444_0002, 64'h4444_0001},
                0, 32'h0000_4000, 32'h0000_4020, 1'b0);
        check("addr_err_set", addr_err, 1);
        do_read(32'h0000_4040, {64'h4545_0004, 64'h4545_0003, 64'h4545_0002, 64'h4545_0001},
                0, 32'h0000_4040, 32'h0000_4040, 1'b0);
        check("addr_err_sticky", addr_err, 1);
`else
        do_read(32'h0000_4000, {64'h4444_0004, 64'h4444_0003, 64'h4444_0002, 64'h4444_0001},
                0, 32'h0000_4000, 32'h0000_4020, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
